// File: rtl/add_one_accum_pkg.sv
// ---------------------------------------------------------------------------
// add_one_accum_pkg
// Shared constants for the add_one result accumulator: default widths and
// sizes, counter widths, and the two-state FSM encoding.
// ---------------------------------------------------------------------------
package add_one_accum_pkg;

  localparam int DEF_DATA_W     = 32;  // incoming result word width
  localparam int DEF_ACC_W      = 40;  // block sum width (wraps)
  localparam int DEF_BLOCK_LEN  = 8;   // results per block, 2..255
  localparam int DEF_FIFO_DEPTH = 4;   // power of two, >= 2

  localparam int BEAT_W   = 8;         // holds BLOCK_LEN-1 up to 254
  localparam int BLOCKS_W = 16;        // emitted-sum counter width

  typedef logic [0:0] state_t;

  localparam state_t ST_ACC  = 1'b0;   // popping and summing words
  localparam state_t ST_EMIT = 1'b1;   // presenting a sum downstream

endpackage : add_one_accum_pkg

// File: rtl/add_one_accum_if.sv
// ---------------------------------------------------------------------------
// add_one_accum_if
// Bundles both busy/vld channels of the accumulator plus its block counter.
//   in_vld/in_data   : result words from add_one (producer -> accumulator)
//   in_busy          : accumulator cannot accept a word
//   out_vld/out_data : block sum (accumulator -> downstream)
//   out_busy         : downstream cannot accept a sum
//   blocks_done      : number of sums handed downstream, wraps at 2^16
// Modports: master = the environment (producer + consumer), slave = the
// accumulator.
// ---------------------------------------------------------------------------
interface add_one_accum_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40
);

  logic              in_vld;
  logic [DATA_W-1:0] in_data;
  logic              in_busy;
  logic              out_busy;
  logic              out_vld;
  logic [ACC_W-1:0]  out_data;
  logic [15:0]       blocks_done;

  modport master (
    output in_vld, in_data, out_busy,
    input  in_busy, out_vld, out_data, blocks_done
  );

  modport slave (
    input  in_vld, in_data, out_busy,
    output in_busy, out_vld, out_data, blocks_done
  );

endinterface : add_one_accum_if

// File: rtl/add_one_accum_fifo.sv
// ---------------------------------------------------------------------------
// add_one_accum_fifo
// Synchronous FIFO without fall-through: a word written on one edge is
// visible on dout (and poppable) from the following edge on.
//   clk, rst : clock, synchronous active-low reset
//   push/din : write request and data (ignored when full)
//   pop      : read request (ignored when empty), dout shows the head
//   full     : count == FIFO_DEPTH
//   empty    : count == 0
// ---------------------------------------------------------------------------
module add_one_accum_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because the depth is a power of two.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is never read before it
  // has been written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule : add_one_accum_fifo

// File: rtl/add_one_accum.sv
// ---------------------------------------------------------------------------
// add_one_accum
// Sink for the add_one result stream. Buffers incoming words, sums blocks of
// BLOCK_LEN words modulo 2^ACC_W and offers each sum on a busy/vld channel.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-low reset
//   bus  : add_one_accum_if.slave (in_vld/in_data/in_busy,
//          out_busy/out_vld/out_data, blocks_done)
// ---------------------------------------------------------------------------
module add_one_accum
  import add_one_accum_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int BLOCK_LEN  = DEF_BLOCK_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  add_one_accum_if.slave    bus
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_LEN - 1);

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 out_vld_q, out_vld_d;
  logic [ACC_W-1:0]     out_data_q, out_data_d;
  logic [BLOCKS_W-1:0]  blocks_done_q, blocks_done_d;

  logic                 in_busy;
  logic                 fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic [DATA_W-1:0]    fifo_dout;
  logic [ACC_W-1:0]     acc_sum;

  // Busy during reset as well, so nothing upstream counts as transferred.
  assign in_busy   = fifo_full | ~rst;
  assign fifo_push = bus.in_vld & ~in_busy;

  add_one_accum_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (bus.in_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Zero-extended head added to the running sum; wraps modulo 2^ACC_W.
  assign acc_sum = acc_q + ACC_W'(fifo_dout);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    beat_d        = beat_q;
    out_vld_d     = out_vld_q;
    out_data_d    = out_data_q;
    blocks_done_d = blocks_done_q;
    fifo_pop      = 1'b0;

    case (state_q)
      ST_ACC: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          acc_d    = acc_sum;
          if (beat_q == LAST_BEAT) begin
            out_data_d = acc_sum;
            out_vld_d  = 1'b1;
            beat_d     = '0;
            state_d    = ST_EMIT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        // ST_EMIT: no pops; the FIFO keeps filling until the sum is taken.
        if (out_vld_q && !bus.out_busy) begin
          out_vld_d     = 1'b0;
          acc_d         = '0;
          blocks_done_d = blocks_done_q + 1'b1;
          state_d       = ST_ACC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_ACC;
      acc_q         <= '0;
      beat_q        <= '0;
      out_vld_q     <= 1'b0;
      out_data_q    <= '0;
      blocks_done_q <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      beat_q        <= beat_d;
      out_vld_q     <= out_vld_d;
      out_data_q    <= out_data_d;
      blocks_done_q <= blocks_done_d;
    end
  end

  assign bus.in_busy     = in_busy;
  assign bus.out_vld     = out_vld_q;
  assign bus.out_data    = out_data_q;
  assign bus.blocks_done = blocks_done_q;

endmodule : add_one_accum
